exception_unit: RTL
===================

EXCEPTION_UNIT -- requirements
Module: exception_unit

Interface
REQ-001 Parameter: MTVEC_RST, default 32'h0000_0000, the reset value of mtvec.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rstn  in  1  reset, asynchronous, active-low.
REQ-004 valid_wb  in  1  a committing instruction is present in the WB stage this cycle.
REQ-005 exp_vector  in  2  decoder exception flags: [1] illegal instruction, [0] ECALL.
REQ-006 mret  in  1  the WB instruction is MRET.
REQ-007 csr_rw  in  1  the WB instruction is a CSR access.
REQ-008 csr_w_imm_mux  in  1  CSR write source: 1 = zimm, 0 = rs1 data.
REQ-009 csr_op  in  2  funct3[1:0]: 01 write, 10 set, 11 clear; 00 means no operation.
REQ-010 csr_addr  in  12  CSR address.
REQ-011 csr_rs1_data  in  32  rs1 operand.
REQ-012 csr_zimm  in  5  immediate operand, zero-extended to 32 bits.
REQ-013 inst_wb / pc_wb / pc_next_wb  in  32 each  WB instruction word, its PC, and its successor PC.
REQ-014 ext_int  in  1  machine external interrupt request, level-sensitive.
REQ-015 csr_r_data  out  32  combinational old value of the CSR at csr_addr.
REQ-016 wb_cancel  out  1  suppress the WB register write this cycle.
REQ-017 flush_all  out  1  squash the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
REQ-018 redirect_valid / redirect_pc  out  1 / 32  PC redirect request and its target.
REQ-019 trap_busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-020 Implemented CSRs:
- mstatus 0x300: bit 3 MIE, bit 7 MPIE, bits [12:11] MPP read as 2'b11; all other bits read 0 and ignore writes.
- mie 0x304: only bit 11 (MEIE) is writable.
- mtvec 0x305, mepc 0x341, mcause 0x342, mtval 0x343: full 32-bit read/write.
- mip 0x344: read-only; bit 11 = ext_int, all other bits 0.
REQ-021 An unimplemented address SHALL read 0 and ignore writes.
REQ-022 CSR update new value, written at the clock edge when valid_wb & csr_rw & no trap:
- write: src
- set: old | src
- clear: old & ~src
where src = csr_w_imm_mux ? {27'b0, zimm} : rs1.
REQ-023 FSM states SHALL be IDLE and REDIRECT; all inputs are evaluated only in IDLE.
REQ-024 Interrupt condition: valid_wb & ext_int & mstatus.MIE & mie.MEIE & ~mret.
REQ-025 Trap priority: interrupt > illegal > ECALL.
REQ-026 In the trap cycle T, flush_all = 1 combinationally; wb_cancel = 1 for synchronous exceptions only, since an interrupted instruction retires.
REQ-027 CSR effects at the end of T:
- mepc <= pc_wb (synchronous exception) or pc_next_wb (interrupt).
- mcause <= 32'h8000_000B (interrupt), 2 (illegal), or 11 (ECALL).
- mtval <= inst_wb for illegal, 0 otherwise.
- MPIE <= MIE; MIE <= 0.
REQ-028 For valid_wb & mret in IDLE: flush_all = 1 in cycle T; at the end of T, MIE <= MPIE and MPIE <= 1.
REQ-029 On any trap or mret, the FSM SHALL enter REDIRECT with redirect_pc latched from pre-edge values: {mtvec[31:2], 2'b00} for a trap, mepc for mret.
REQ-030 REDIRECT SHALL last exactly one cycle, with redirect_valid = 1 and flush_all = 1, then return to IDLE.
REQ-031 In REDIRECT, valid_wb SHALL be ignored: no CSR write, no trap, wb_cancel = 0.
REQ-032 A CSR instruction interrupted in the same cycle SHALL complete its write, except that trap-updated fields (mepc, mcause, mtval, mstatus) take the trap value.
REQ-033 A CSR write to mtvec or mepc in the same cycle as a trap or mret SHALL NOT affect the latched redirect_pc.
REQ-034 With mret and ext_int both pending, the interrupt SHALL be deferred to a later IDLE cycle.
REQ-035 Minimum trap-to-redirect latency SHALL be 1 cycle; back-to-back traps SHALL be at least 2 cycles apart.

Reset
REQ-036 While rstn = 0: FSM = IDLE; mstatus = 32'h0000_1800; mie, mepc, mcause, mtval = 0; mtvec = MTVEC_RST.
REQ-037 While rstn = 0: all registered outputs = 0, and combinational outputs evaluate to 0 because valid_wb is ignored.
REQ-038 Reset asserted in REDIRECT SHALL abort the redirect immediately, with redirect_valid = 0 asynchronously.

Verification
REQ-039 ECALL: mtvec = 0x100, valid_wb, exp_vector = 01, pc_wb = 0x40.
- Cycle T: flush_all = 1, wb_cancel = 1.
- Cycle T+1: redirect_valid = 1, redirect_pc = 0x100; mepc = 0x40, mcause = 11, MIE = 0.
REQ-040 Illegal instruction: inst_wb = 0xFFFF_FFFF with exp_vector = 10 -> mcause = 2, mtval = 0xFFFF_FFFF.
REQ-041 MRET: mepc = 0x44, MPIE = 1, MIE = 0, mret -> T+1 redirect_pc = 0x44; MIE = 1, MPIE = 1.
REQ-042 Interrupt on CSR instruction: MIE = 1, MEIE = 1, ext_int = 1, CSRRW mtvec <- 0x200 with old mtvec = 0x100, pc_next_wb = 0x58.
- Expected: redirect_pc = 0x100, mtvec = 0x200, mepc = 0x58, mcause = 0x8000_000B, wb_cancel = 0.
REQ-043 CSR set/clear and unimplemented address:
- CSRRSI 0x300 zimm = 8 -> MIE = 1.
- CSRRC 0x300 with rs1 = 8 -> MIE = 0.
- CSRRW 0x7C0 -> reads 0, no state change.
REQ-044 Reset abort: rstn pulled low mid-REDIRECT -> redirect_valid drops without waiting for a clock edge; after release, mstatus = 0x1800.

Source files
------------

// File: rtl/exception_unit.sv
// Machine-mode exception unit: holds the trap CSRs, executes CSR
// read/modify/write from WB, takes ECALL / illegal / external interrupt
// traps and MRET, and issues a one-cycle PC redirect afterwards.
module exception_unit #(
   parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        valid_wb,
   input  logic [1:0]  exp_vector,
   input  logic        mret,
   input  logic        csr_rw,
   input  logic        csr_w_imm_mux,
   input  logic [1:0]  csr_op,
   input  logic [11:0] csr_addr,
   input  logic [31:0] csr_rs1_data,
   input  logic [4:0]  csr_zimm,
   input  logic [31:0] inst_wb,
   input  logic [31:0] pc_wb,
   input  logic [31:0] pc_next_wb,
   input  logic        ext_int,
   output logic [31:0] csr_r_data,
   output logic        wb_cancel,
   output logic        flush_all,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        trap_busy
);

   localparam logic [11:0] A_MSTATUS = 12'h300;
   localparam logic [11:0] A_MIE     = 12'h304;
   localparam logic [11:0] A_MTVEC   = 12'h305;
   localparam logic [11:0] A_MEPC    = 12'h341;
   localparam logic [11:0] A_MCAUSE  = 12'h342;
   localparam logic [11:0] A_MTVAL   = 12'h343;
   localparam logic [11:0] A_MIP     = 12'h344;

   typedef enum logic {S_IDLE, S_REDIRECT} state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic        r_mie;       // mstatus.MIE
   logic        r_mpie;      // mstatus.MPIE
   logic        r_meie;      // mie.MEIE
   logic [31:0] r_mtvec;
   logic [31:0] r_mepc;
   logic [31:0] r_mcause;
   logic [31:0] r_mtval;
   logic [31:0] r_redirect_pc;

   logic        w_active;
   logic        w_int;
   logic        w_ill;
   logic        w_ecall;
   logic        w_trap;
   logic        w_sync_exc;
   logic        w_do_mret;
   logic        w_csr_we;
   logic [31:0] w_src;
   logic [31:0] w_csr_new;

   // WB inputs only matter in IDLE and never while reset is held.
   assign w_active   = rstn & (r_state == S_IDLE) & valid_wb;
   assign w_int      = w_active & ext_int & r_mie & r_meie & ~mret;
   assign w_ill      = w_active & exp_vector[1];
   assign w_ecall    = w_active & exp_vector[0];
   assign w_trap     = w_int | w_ill | w_ecall;
   assign w_sync_exc = w_trap & ~w_int;
   // A faulting MRET traps instead of returning.
   assign w_do_mret  = w_active & mret & ~w_trap;
   // An interrupted instruction retires, so its CSR write still happens.
   assign w_csr_we   = w_active & csr_rw & (csr_op != 2'b00) & ~w_sync_exc;

   assign w_src = csr_w_imm_mux ? {27'b0, csr_zimm} : csr_rs1_data;

   // Combinational CSR read of the pre-edge value.
   always_comb begin
      csr_r_data = 32'h0;
      case (csr_addr)
         A_MSTATUS: csr_r_data = {19'b0, 2'b11, 3'b0, r_mpie, 3'b0, r_mie, 3'b0};
         A_MIE:     csr_r_data = {20'b0, r_meie, 11'b0};
         A_MTVEC:   csr_r_data = r_mtvec;
         A_MEPC:    csr_r_data = r_mepc;
         A_MCAUSE:  csr_r_data = r_mcause;
         A_MTVAL:   csr_r_data = r_mtval;
         A_MIP:     csr_r_data = {20'b0, ext_int, 11'b0};
         default:   csr_r_data = 32'h0;
      endcase
   end

   // Read-modify-write value for the CSR instruction.
   always_comb begin
      w_csr_new = csr_r_data;
      case (csr_op)
         2'b01:   w_csr_new = w_src;
         2'b10:   w_csr_new = csr_r_data | w_src;
         2'b11:   w_csr_new = csr_r_data & ~w_src;
         default: w_csr_new = csr_r_data;
      endcase
   end

   // CSR state: instruction write first, trap/MRET updates override it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_mie    <= 1'b0;
         r_mpie   <= 1'b0;
         r_meie   <= 1'b0;
         r_mtvec  <= MTVEC_RST;
         r_mepc   <= 32'h0;
         r_mcause <= 32'h0;
         r_mtval  <= 32'h0;
      end else begin
         if (w_csr_we) begin
            case (csr_addr)
               A_MSTATUS: begin
                  r_mie  <= w_csr_new[3];
                  r_mpie <= w_csr_new[7];
               end
               A_MIE:    r_meie   <= w_csr_new[11];
               A_MTVEC:  r_mtvec  <= w_csr_new;
               A_MEPC:   r_mepc   <= w_csr_new;
               A_MCAUSE: r_mcause <= w_csr_new;
               A_MTVAL:  r_mtval  <= w_csr_new;
               default: ;
            endcase
         end
         if (w_trap) begin
            r_mepc   <= w_int ? pc_next_wb : pc_wb;
            r_mcause <= w_int ? 32'h8000_000B : (w_ill ? 32'd2 : 32'd11);
            r_mtval  <= (~w_int & w_ill) ? inst_wb : 32'h0;
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
         end else if (w_do_mret) begin
            r_mie  <= r_mpie;
            r_mpie <= 1'b1;
         end
      end
   end

   // Redirect target captured from pre-edge mtvec / mepc.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_redirect_pc <= 32'h0;
      end else if (w_trap) begin
         r_redirect_pc <= {r_mtvec[31:2], 2'b00};
      end else if (w_do_mret) begin
         r_redirect_pc <= r_mepc;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   // FSM next state: REDIRECT always lasts a single cycle.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:     if (w_trap | w_do_mret) w_state_next = S_REDIRECT;
         S_REDIRECT: w_state_next = S_IDLE;
         default:    w_state_next = S_IDLE;
      endcase
   end

   assign redirect_valid = (r_state == S_REDIRECT);
   assign trap_busy      = (r_state != S_IDLE);
   assign redirect_pc    = r_redirect_pc;
   assign flush_all      = w_trap | w_do_mret | redirect_valid;
   assign wb_cancel      = w_sync_exc;

endmodule
